// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the MEM stage: FSM state encoding, bus width,
// the default ack timeout and the poison word returned after a timeout.
package mem_access_stage_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;
  localparam logic [DATA_W-1:0] POISON_DEF   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;

  logic                                     mem_req;
  logic                                     mem_we;
  logic [mem_access_stage_pkg::DATA_W-1:0]  mem_addr;
  logic [mem_access_stage_pkg::DATA_W-1:0]  mem_wdata;
  logic [mem_access_stage_pkg::DATA_W-1:0]  mem_rdata;
  logic                                     mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating 8-bit wait counter; expired flags the cycle on which the count
// of waited cycles reaches LIMIT, so the caller can give up on that same cycle.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: non-memory ops pass straight through, aligned loads/stores
// stall the pipe while a request/ack transaction runs on the data-memory bus.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] POISON         = POISON_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              MRead_in,
  input  logic              MWrite_in,
  input  logic              MReg_in,
  input  logic              EnRW_in,
  input  logic [DATA_W-1:0] ALU_out_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [3:0]        reg_rd_in,
  output logic              MReg_out,
  output logic              EnRW_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] ALU_out_out,
  output logic [3:0]        reg_rd_out,
  output logic              stall_out,
  mem_access_stage_if.master mem,
  output logic              err_misalign,
  output logic              err_timeout,
  input  logic              err_clr
);

  state_e            state_p0, state_nxt;
  logic              req_p1, we_p1;
  logic [DATA_W-1:0] addr_p1, wdata_p1, rdata_p1;
  logic              killed_p1;
  logic              start_op, set_misalign, set_timeout, acked;
  logic              mem_op, aligned;
  logic [7:0]        wait_cnt_unused;
  logic              tmr_expired;

  assign mem_op  = valid_in & (MRead_in | MWrite_in);
  assign aligned = (ALU_out_in[1:0] == 2'b00);
  assign acked   = (state_p0 == BUSY) & mem.mem_ack;

  mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_p0 != BUSY),
    .enable  ((state_p0 == BUSY) & ~mem.mem_ack),
    .count   (wait_cnt_unused),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nxt     = state_p0;
    stall_out     = 1'b0;
    EnRW_out      = 1'b0;
    MReg_out      = MReg_in;
    ALU_out_out   = ALU_out_in;
    reg_rd_out    = reg_rd_in;
    read_data_out = '0;
    start_op      = 1'b0;
    set_misalign  = 1'b0;
    set_timeout   = 1'b0;
    case (state_p0)
      IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            stall_out = 1'b1;
            start_op  = 1'b1;
            state_nxt = BUSY;
          end else begin
            set_misalign = 1'b1;
          end
        end else begin
          EnRW_out = valid_in & EnRW_in;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        // An ack on the expiry cycle still wins over the timeout.
        if (mem.mem_ack) begin
          state_nxt = DONE;
        end else if (tmr_expired) begin
          set_timeout = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        read_data_out = rdata_p1;
        EnRW_out      = EnRW_in & ~killed_p1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing retires while reset is being applied.
    if (!rst_n) EnRW_out = 1'b0;
  end

  // ---- bus request / capture registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0  <= IDLE;
      req_p1    <= 1'b0;
      we_p1     <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      rdata_p1  <= '0;
      killed_p1 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (start_op) begin
        req_p1    <= 1'b1;
        we_p1     <= MWrite_in;
        addr_p1   <= ALU_out_in;
        wdata_p1  <= store_data_in;
        rdata_p1  <= '0;
        killed_p1 <= 1'b0;
      end else if (acked) begin
        req_p1   <= 1'b0;
        rdata_p1 <= we_p1 ? '0 : mem.mem_rdata;
      end else if (set_timeout) begin
        req_p1    <= 1'b0;
        rdata_p1  <= POISON;
        killed_p1 <= 1'b1;
      end
    end
  end

  // ---- sticky error flags, set beats clear ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= set_misalign | (err_misalign & ~err_clr);
      err_timeout  <= set_timeout  | (err_timeout  & ~err_clr);
    end
  end

  assign mem.mem_req   = req_p1;
  assign mem.mem_we    = we_p1;
  assign mem.mem_addr  = addr_p1;
  assign mem.mem_wdata = wdata_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a hand-driven data-memory responder.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, MRead_in, MWrite_in, MReg_in, EnRW_in;
  logic [31:0] ALU_out_in, store_data_in;
  logic [3:0]  reg_rd_in;
  logic        MReg_out, EnRW_out, stall_out;
  logic [31:0] read_data_out, ALU_out_out;
  logic [3:0]  reg_rd_out;
  logic        err_misalign, err_timeout, err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls, reqs;

  mem_access_stage_if mif ();

  mem_access_stage #(.TIMEOUT_CYCLES(4), .POISON(32'hDEAD_BEEF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .MRead_in      (MRead_in),
    .MWrite_in     (MWrite_in),
    .MReg_in       (MReg_in),
    .EnRW_in       (EnRW_in),
    .ALU_out_in    (ALU_out_in),
    .store_data_in (store_data_in),
    .reg_rd_in     (reg_rd_in),
    .MReg_out      (MReg_out),
    .EnRW_out      (EnRW_out),
    .read_data_out (read_data_out),
    .ALU_out_out   (ALU_out_out),
    .reg_rd_out    (reg_rd_out),
    .stall_out     (stall_out),
    .mem           (mif.master),
    .err_misalign  (err_misalign),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic mreg,
                        input logic enrw, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [3:0] dst);
    valid_in = v; MRead_in = rd; MWrite_in = wr; MReg_in = mreg; EnRW_in = enrw;
    ALU_out_in = alu; store_data_in = sd; reg_rd_in = dst;
  endtask

  // Called in the IDLE cycle just after driving a memory op; returns in DONE.
  task automatic run_op(input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] ea, input logic ewe, input logic [31:0] ewd,
                        output int n_stall, output int n_req);
    n_stall = 0;
    n_req   = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_out) return;
      n_stall++;
      check_eq("stall_enrw", 32'(EnRW_out), 32'd0);
      if (mif.mem_req) begin
        n_req++;
        check_eq("bus_addr", mif.mem_addr, ea);
        check_eq("bus_we", 32'(mif.mem_we), 32'(ewe));
        if (ewe) check_eq("bus_wdata", mif.mem_wdata, ewd);
        if (n_req == ack_at) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rdata;
        end
      end
      tick();
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'h0BAD_0BAD;
    end
    check_eq("op_bound", 32'(stall_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0BAD_0BAD;
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    #1;
    check_eq("rst_req",   32'(mif.mem_req), 32'd0);
    check_eq("rst_we",    32'(mif.mem_we), 32'd0);
    check_eq("rst_addr",  mif.mem_addr, 32'd0);
    check_eq("rst_wdata", mif.mem_wdata, 32'd0);
    check_eq("rst_errm",  32'(err_misalign), 32'd0);
    check_eq("rst_errt",  32'(err_timeout), 32'd0);
    check_eq("rst_stall", 32'(stall_out), 32'd0);
    tick();
    rst_n = 1'b1;

    // ADD pass-through
    tick();
    set_op(1, 0, 0, 0, 1, 32'h10, 32'h0, 4'd3);
    #1;
    check_eq("add_enrw",  32'(EnRW_out), 32'd1);
    check_eq("add_alu",   ALU_out_out, 32'h10);
    check_eq("add_rd",    32'(reg_rd_out), 32'd3);
    check_eq("add_stall", 32'(stall_out), 32'd0);
    check_eq("add_rdata", read_data_out, 32'd0);
    check_eq("add_req",   32'(mif.mem_req), 32'd0);
    tick();
    set_op(0, 0, 0, 0, 1, 32'h10, 32'h0, 4'd3);
    #1;
    check_eq("bubble_enrw", 32'(EnRW_out), 32'd0);

    // Load 0x40, ack on third BUSY cycle
    tick();
    set_op(1, 1, 0, 1, 1, 32'h40, 32'h0, 4'd5);
    run_op(3, 32'h1234_5678, 32'h40, 1'b0, 32'h0, stalls, reqs);
    check_eq("ld_stalls", 32'(stalls), 32'd4);
    check_eq("ld_reqs",   32'(reqs), 32'd3);
    check_eq("ld_rdata",  read_data_out, 32'h1234_5678);
    check_eq("ld_enrw",   32'(EnRW_out), 32'd1);
    check_eq("ld_alu",    ALU_out_out, 32'h40);
    check_eq("ld_rd",     32'(reg_rd_out), 32'd5);
    check_eq("ld_done_req", 32'(mif.mem_req), 32'd0);
    tick();
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    #1;
    check_eq("ld_idle_stall", 32'(stall_out), 32'd0);

    // Store 0x44, ack in first BUSY cycle
    tick();
    set_op(1, 0, 1, 0, 0, 32'h44, 32'h0000_CAFE, 4'd0);
    run_op(1, 32'h0, 32'h44, 1'b1, 32'h0000_CAFE, stalls, reqs);
    check_eq("st_stalls", 32'(stalls), 32'd2);
    check_eq("st_reqs",   32'(reqs), 32'd1);
    check_eq("st_enrw",   32'(EnRW_out), 32'd0);
    check_eq("st_rdata",  read_data_out, 32'd0);

    // MRead and MWrite both set behaves as a store
    tick();
    set_op(1, 1, 1, 0, 0, 32'h48, 32'h0000_0077, 4'd0);
    run_op(1, 32'hFFFF_FFFF, 32'h48, 1'b1, 32'h77, stalls, reqs);
    check_eq("rw_reqs",  32'(reqs), 32'd1);
    check_eq("rw_rdata", read_data_out, 32'd0);

    // Load timeout
    tick();
    set_op(1, 1, 0, 1, 1, 32'h80, 32'h0, 4'd7);
    run_op(0, 32'h0, 32'h80, 1'b0, 32'h0, stalls, reqs);
    check_eq("to_reqs",   32'(reqs), 32'd4);
    check_eq("to_stalls", 32'(stalls), 32'd5);
    check_eq("to_rdata",  read_data_out, 32'hDEAD_BEEF);
    check_eq("to_enrw",   32'(EnRW_out), 32'd0);
    check_eq("to_err",    32'(err_timeout), 32'd1);
    tick();
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    err_clr = 1'b1;
    #1;
    check_eq("to_sticky", 32'(err_timeout), 32'd1);
    tick();
    err_clr = 1'b0;
    #1;
    check_eq("to_clr", 32'(err_timeout), 32'd0);

    // Ack on the expiry cycle counts as success
    tick();
    set_op(1, 1, 0, 0, 1, 32'h90, 32'h0, 4'd2);
    run_op(4, 32'hA5A5_0001, 32'h90, 1'b0, 32'h0, stalls, reqs);
    check_eq("edge_reqs",  32'(reqs), 32'd4);
    check_eq("edge_rdata", read_data_out, 32'hA5A5_0001);
    check_eq("edge_enrw",  32'(EnRW_out), 32'd1);
    check_eq("edge_err",   32'(err_timeout), 32'd0);

    // Misaligned load
    tick();
    set_op(1, 1, 0, 0, 1, 32'h42, 32'h0, 4'd1);
    #1;
    check_eq("mis_stall", 32'(stall_out), 32'd0);
    check_eq("mis_enrw",  32'(EnRW_out), 32'd0);
    tick();
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    #1;
    check_eq("mis_req", 32'(mif.mem_req), 32'd0);
    check_eq("mis_err", 32'(err_misalign), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check_eq("mis_clr", 32'(err_misalign), 32'd0);
    tick();
    set_op(1, 1, 0, 0, 1, 32'h43, 32'h0, 4'd1);
    err_clr = 1'b1;
    tick();
    set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    err_clr = 1'b0;
    #1;
    check_eq("mis_set_wins", 32'(err_misalign), 32'd1);

    // Reset during the second BUSY cycle
    tick();
    set_op(1, 1, 0, 0, 1, 32'h50, 32'h0, 4'd4);
    tick();
    #1;
    check_eq("rb_req1", 32'(mif.mem_req), 32'd1);
    tick();
    rst_n = 1'b0;
    set_op(0, 0, 0, 0, 1, 32'h50, 32'h0, 4'd4);
    #1;
    check_eq("rb_enrw_in_rst", 32'(EnRW_out), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rb_req",   32'(mif.mem_req), 32'd0);
    check_eq("rb_stall", 32'(stall_out), 32'd0);
    check_eq("rb_enrw",  32'(EnRW_out), 32'd0);
    check_eq("rb_errm",  32'(err_misalign), 32'd0);
    set_op(1, 0, 0, 0, 1, 32'h20, 32'h0, 4'd6);
    #1;
    check_eq("rb_idle_pass", 32'(EnRW_out), 32'd1);
    check_eq("rb_idle_alu",  ALU_out_out, 32'h20);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
